// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port asynchronous SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  typedef logic port_t;

  localparam port_t PORT0 = 1'b0;
  localparam port_t PORT1 = 1'b1;

  localparam logic STROBE_OFF = 1'b1;
  localparam int   WAIT_W     = 4;

endpackage

// File: rtl/sram_arb_if.sv
// Requester and SRAM-side signal bundle; the arbiter uses the slave view.
interface sram_arb_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic              req0, req1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic              rdwr0, rdwr1;
  logic [DATA_W-1:0] wr_data0, wr_data1;
  logic [DATA_W-1:0] rd_data0, rd_data1;
  logic              ack0, ack1;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_dq_o;
  logic [DATA_W-1:0] sram_dq_i;
  logic              sram_dq_oe;
  logic              sram_ce_n, sram_oe_n, sram_we_n;

  modport slave (
    input  req0, req1, addr0, addr1, rdwr0, rdwr1, wr_data0, wr_data1, sram_dq_i,
    output rd_data0, rd_data1, ack0, ack1, sram_addr, sram_dq_o, sram_dq_oe,
           sram_ce_n, sram_oe_n, sram_we_n
  );

  modport master (
    output req0, req1, addr0, addr1, rdwr0, rdwr1, wr_data0, wr_data1, sram_dq_i,
    input  rd_data0, rd_data1, ack0, ack1, sram_addr, sram_dq_o, sram_dq_oe,
           sram_ce_n, sram_oe_n, sram_we_n
  );
endinterface

// File: rtl/sram_arb_pick.sv
// Combinational grant selection. SRAM_ARB_RR_EN selects round-robin,
// otherwise port 0 has fixed priority.
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic  req0_i,
  input  logic  req1_i,
`ifdef SRAM_ARB_RR_EN
  input  port_t ptr_i,
`endif
  output port_t gnt_o
);

  // Grant decision from the current requests
  always_comb begin
    gnt_o = PORT0;
`ifdef SRAM_ARB_RR_EN
    // ptr_i names the port that did not win last time
    if (req0_i && req1_i) begin
      gnt_o = ptr_i;
    end else if (req1_i) begin
      gnt_o = PORT1;
    end else begin
      gnt_o = PORT0;
    end
`else
    if (req0_i) begin
      gnt_o = PORT0;
    end else if (req1_i) begin
      gnt_o = PORT1;
    end else begin
      gnt_o = PORT0;
    end
`endif
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter for one asynchronous SRAM bank with programmable wait states.
// Arbitration policy is chosen by the SRAM_ARB_RR_EN macro (see sram_arb_pick).
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input logic       clock,
  input logic       reset,
  sram_arb_if.slave bus_if
);

  localparam logic [WAIT_W-1:0] CNT_LOAD = WAIT_W'(WAIT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] CNT_ONE  = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] CNT_ZERO = WAIT_W'(0);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  port_t             gnt_q, gnt_d;
  logic              rdwr_q, rdwr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dq_o_q, dq_o_d;
  logic              dq_oe_q, dq_oe_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rd0_q, rd0_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;
`ifdef SRAM_ARB_RR_EN
  port_t             ptr_q, ptr_d;
`endif

  port_t             pick_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic              sel_rdwr_s;
  logic [DATA_W-1:0] sel_wdata_s;

  sram_arb_pick u_pick (
    .req0_i (bus_if.req0),
    .req1_i (bus_if.req1),
`ifdef SRAM_ARB_RR_EN
    .ptr_i  (ptr_q),
`endif
    .gnt_o  (pick_s)
  );

  assign sel_addr_s  = (pick_s == PORT1) ? bus_if.addr1    : bus_if.addr0;
  assign sel_rdwr_s  = (pick_s == PORT1) ? bus_if.rdwr1    : bus_if.rdwr0;
  assign sel_wdata_s = (pick_s == PORT1) ? bus_if.wr_data1 : bus_if.wr_data0;

  // Next state and next registered outputs; outputs describe the state being entered
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    rdwr_d  = rdwr_q;
    addr_d  = addr_q;
    dq_o_d  = dq_o_q;
    dq_oe_d = 1'b0;
    ce_n_d  = STROBE_OFF;
    oe_n_d  = STROBE_OFF;
    we_n_d  = STROBE_OFF;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
`ifdef SRAM_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus_if.req0 || bus_if.req1) begin
          state_d = SETUP;
          gnt_d   = pick_s;
          rdwr_d  = sel_rdwr_s;
          addr_d  = sel_addr_s;
          dq_o_d  = sel_wdata_s;
          ce_n_d  = 1'b0;
          if (sel_rdwr_s) begin
            oe_n_d = 1'b0;
          end else begin
            dq_oe_d = 1'b1;
          end
`ifdef SRAM_ARB_RR_EN
          ptr_d = ~pick_s;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = CNT_LOAD;
        ce_n_d  = 1'b0;
        if (rdwr_q) begin
          oe_n_d = 1'b0;
        end else begin
          we_n_d  = 1'b0;
          dq_oe_d = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt_q == CNT_ZERO) begin
          // Final ACCESS edge: sample read data and raise the ack for HOLD
          state_d = HOLD;
          if (gnt_q == PORT1) begin
            ack1_d = 1'b1;
          end else begin
            ack0_d = 1'b1;
          end
          if (rdwr_q) begin
            if (gnt_q == PORT1) begin
              rd1_d = bus_if.sram_dq_i;
            end else begin
              rd0_d = bus_if.sram_dq_i;
            end
          end else begin
            dq_oe_d = 1'b1;
          end
        end else begin
          cnt_d  = cnt_q - CNT_ONE;
          ce_n_d = 1'b0;
          if (rdwr_q) begin
            oe_n_d = 1'b0;
          end else begin
            we_n_d  = 1'b0;
            dq_oe_d = 1'b1;
          end
        end
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      gnt_q   <= PORT0;
      rdwr_q  <= 1'b1;
      addr_q  <= {ADDR_W{1'b0}};
      dq_o_q  <= {DATA_W{1'b0}};
      dq_oe_q <= 1'b0;
      ce_n_q  <= STROBE_OFF;
      oe_n_q  <= STROBE_OFF;
      we_n_q  <= STROBE_OFF;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rd0_q   <= {DATA_W{1'b0}};
      rd1_q   <= {DATA_W{1'b0}};
`ifdef SRAM_ARB_RR_EN
      ptr_q   <= PORT0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      rdwr_q  <= rdwr_d;
      addr_q  <= addr_d;
      dq_o_q  <= dq_o_d;
      dq_oe_q <= dq_oe_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
`ifdef SRAM_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign bus_if.sram_addr  = addr_q;
  assign bus_if.sram_dq_o  = dq_o_q;
  assign bus_if.sram_dq_oe = dq_oe_q;
  assign bus_if.sram_ce_n  = ce_n_q;
  assign bus_if.sram_oe_n  = oe_n_q;
  assign bus_if.sram_we_n  = we_n_q;
  assign bus_if.ack0       = ack0_q;
  assign bus_if.ack1       = ack1_q;
  assign bus_if.rd_data0   = rd0_q;
  assign bus_if.rd_data1   = rd1_q;

endmodule
